alu_slice_sequencer: RTL and testbench

Multi-precision controller for the combinational N-bit slice ALU (ctrl[2:0], in0, in1, c_in -> alu_out, c_out, V, Z).
- Accepts one wide operation on SLICES*N-bit operands.
- Drives the slice ALU one N-bit slice per clock, LSB slice first, chaining carry between slices.
- Assembles the wide result and reports wide C/V/Z through a start/busy/done handshake.
- Sits between the register/decode logic and a single shared slice ALU instance.

---
 rtl/alu_slice_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_slice_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer.sv
// Sequences one wide (N*SLICES-bit) operation through a shared N-bit slice ALU, LSB slice first.
// Latency: start accepted on edge T0, done pulses in the cycle after edge T(SLICES).
// Backpressure: none; start is ignored while busy, and is accepted in IDLE or in the DONE cycle.
module alu_slice_sequencer #(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [N*SLICES-1:0]   a,
    input  logic [N*SLICES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [N*SLICES-1:0]   result,
    output logic                  c_out,
    output logic                  v,
    output logic                  z,
    output logic [N-1:0]          alu_in0,
    output logic [N-1:0]          alu_in1,
    output logic                  alu_c_in,
    output logic [2:0]            alu_ctrl,
    input  logic [N-1:0]          alu_out_i,
    input  logic                  alu_c_out_i,
    input  logic                  alu_v_i
);

    localparam int W  = N * SLICES;
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2:0]      op_q;
    logic            carry_q;
    logic [IW-1:0]   idx;
    logic            accept;
    logic [W-1:0]    result_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and the slice ALU drive (zero outside RUN).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        alu_in0   = '0;
        alu_in1   = '0;
        alu_c_in  = 1'b0;
        alu_ctrl  = 3'b000;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                alu_in0  = a_q[idx*N +: N];
                alu_in1  = b_q[idx*N +: N];
                alu_c_in = carry_q;
                alu_ctrl = op_q;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
                // A start here chains straight into the next operation.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wide result with the current slice merged in; z on the last slice looks at this value.
    always_comb begin
        result_nxt = result;
        result_nxt[idx*N +: N] = alu_out_i;
    end

    // Operand capture, slice assembly, carry chaining and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            v       <= 1'b0;
            z       <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            result  <= result_nxt;
            carry_q <= alu_c_out_i;
            if (idx == LAST) begin
                // Reset the index here rather than letting it wrap, so non-power-of-two
                // slice counts never address past the operand.
                idx   <= '0;
                c_out <= alu_c_out_i;
                v     <= alu_v_i;
                z     <= (result_nxt == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Self-checking bench: a behavioural slice ALU drives the DUT, wide results are predicted arithmetically.
// Latency: expects done exactly SLICES+1 cycles after start is driven.
// Backpressure: exercises start held during RUN and start in the DONE cycle.
module tb_alu_slice_sequencer;

    localparam int N      = 4;
    localparam int SLICES = 4;
    localparam int W      = N * SLICES;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             c_out;
    logic             v;
    logic             z;
    logic [N-1:0]     alu_in0;
    logic [N-1:0]     alu_in1;
    logic             alu_c_in;
    logic [2:0]       alu_ctrl;
    logic [N-1:0]     alu_out_i;
    logic             alu_c_out_i;
    logic             alu_v_i;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] bp;
        logic [W-1:0] res;
        logic [2:0]   op;
        logic         cin;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t q[$];

    alu_slice_sequencer #(.N(N), .SLICES(SLICES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .c_out       (c_out),
        .v           (v),
        .z           (z),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_c_in    (alu_c_in),
        .alu_ctrl    (alu_ctrl),
        .alu_out_i   (alu_out_i),
        .alu_c_out_i (alu_c_out_i),
        .alu_v_i     (alu_v_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural N-bit slice ALU; carry and overflow always come from the adder path.
    logic [N:0]   s_sum;
    logic [N-1:0] s_bp;
    always_comb begin
        s_bp  = alu_ctrl[0] ? ~alu_in1 : alu_in1;
        s_sum = {1'b0, alu_in0} + {1'b0, s_bp} + {{N{1'b0}}, alu_c_in};
        case (alu_ctrl)
            3'd0, 3'd1: alu_out_i = s_sum[N-1:0];
            3'd2:       alu_out_i = alu_in0 | alu_in1;
            3'd3:       alu_out_i = alu_in0 | ~alu_in1;
            3'd4:       alu_out_i = alu_in0 & alu_in1;
            3'd5:       alu_out_i = alu_in0 & ~alu_in1;
            3'd6:       alu_out_i = ~alu_in0;
            default:    alu_out_i = ~alu_in1;
        endcase
        alu_c_out_i = s_sum[N];
        alu_v_i     = (alu_in0[N-1] == s_bp[N-1]) && (s_sum[N-1] != alu_in0[N-1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Wide reference: the whole operation computed at once on W-bit values.
    task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input logic [2:0] top);
        exp_t       e;
        logic [W:0] s;
        e.a   = ta;
        e.b   = tbv;
        e.cin = tc;
        e.op  = top;
        e.bp  = top[0] ? ~tbv : tbv;
        s     = {1'b0, ta} + {1'b0, e.bp} + {{W{1'b0}}, tc};
        case (top)
            3'd0, 3'd1: e.res = s[W-1:0];
            3'd2:       e.res = ta | tbv;
            3'd3:       e.res = ta | ~tbv;
            3'd4:       e.res = ta & tbv;
            3'd5:       e.res = ta & ~tbv;
            3'd6:       e.res = ~ta;
            default:    e.res = ~tbv;
        endcase
        e.c = s[W];
        e.v = (ta[W-1] == e.bp[W-1]) && (s[W-1] != ta[W-1]);
        e.z = (e.res == '0);
        q.push_back(e);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        cin   = tc;
        op    = top;
    endtask

    // Carry into slice j = carry out of the low j*N bits of the wide sum.
    function automatic logic carry_into(input exp_t e, input int j);
        longint unsigned m;
        longint unsigned s;
        if (j == 0) return e.cin;
        m = (64'd1 << (j * N)) - 64'd1;
        s = (longint'(e.a) & m) + (longint'(e.bp) & m) + longint'(e.cin);
        return s[j * N];
    endfunction

    // Called #1 after the accepting edge; checks kmax RUN cycles.
    task automatic run_slices(input bit hold, input int kmax);
        exp_t         e;
        logic [W-1:0] t;
        logic [N-1:0] sl;
        e = q[0];
        if (!hold) start = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            t = e.a >> ((k - 1) * N);
            sl = t[N-1:0];
            chk("alu_in0", alu_in0, sl);
            t = e.b >> ((k - 1) * N);
            sl = t[N-1:0];
            chk("alu_in1", alu_in1, sl);
            chk("alu_c_in", alu_c_in, carry_into(e, k - 1));
            chk("alu_ctrl", alu_ctrl, e.op);
            @(posedge clk);
            #1;
            if (hold && k < SLICES) begin
                a  = W'($urandom);
                b  = W'($urandom);
                op = 3'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        e = q.pop_front();
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_c_out"}, c_out, e.c);
        chk({tag, "_v"}, v, e.v);
        chk({tag, "_z"}, z, e.z);
        chk({tag, "_alu_idle"}, {alu_in0, alu_in1, alu_c_in, alu_ctrl}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic one_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input logic [2:0] top);
        set_op(ta, tbv, tc, top);
        @(posedge clk);
        #1;
        run_slices(1'b0, SLICES);
        check_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] held;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {c_out, v, z}, 0);
        chk("rst_alu", {alu_in0, alu_in1, alu_c_in, alu_ctrl}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Add with full carry ripple; then result/flags hold while idle.
        one_op("add", 16'hFFFF, 16'h0001, 1'b0, 3'd0);
        @(negedge clk);
        chk("hold_result", result, 16'h0000);
        chk("hold_z", z, 1);
        chk("hold_done", done, 0);
        @(posedge clk);
        #1;

        one_op("sub", 16'h8000, 16'h0001, 1'b1, 3'd1);
        one_op("and", 16'hF0F0, 16'h0FF0, 1'b0, 3'd4);
        one_op("or0", 16'h0000, 16'h0000, 1'b0, 3'd2);

        // start held high with changing operands during RUN is ignored.
        set_op(16'h1357, 16'h2468, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        run_slices(1'b1, SLICES);
        check_done("held");

        // Back-to-back: second start lands in the DONE cycle of the first.
        set_op(16'h00FF, 16'h0F0F, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        run_slices(1'b0, SLICES);
        set_op(16'h4000, 16'h4000, 1'b0, 3'd0);
        check_done("b2b1");
        run_slices(1'b0, SLICES);
        check_done("b2b2");

        // Reset during slice 2 aborts without a done pulse.
        set_op(16'hFFFF, 16'hFFFF, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        run_slices(1'b0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        held = q[0].res;
        q.delete(0);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {c_out, v, z}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        @(posedge clk);
        #1;
        one_op("post_rst", 16'h1234, 16'h1111, 1'b0, 3'd0);
        chk("post_rst_value", result, 16'h2345);

        // Randomized operations over every op code.
        for (int i = 0; i < 24; i++) begin
            one_op("rand", W'($urandom), W'($urandom), 1'($urandom), 3'($urandom_range(7, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
